// File: rtl/sdr_cmd_pkg.sv
// sdr_cmd_pkg: SDR command encodings, error bit indices and init states shared by the command monitor
package sdr_cmd_pkg;
    localparam logic [2:0] CMD_MRS   = 3'b000;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_BST   = 3'b110;
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam int ERR_INIT     = 0;
    localparam int ERR_TRP      = 1;
    localparam int ERR_TRCD     = 2;
    localparam int ERR_TRFC     = 3;
    localparam int ERR_TMRD     = 4;
    localparam int ERR_BANK     = 5;
    localparam int ERR_REF_LATE = 6;
    typedef enum logic [1:0] {WAIT_PRE, WAIT_REF, WAIT_MRS, DONE} init_e;
    // a window of N clocks is held as N-1 so the dependent command is legal once it reads 0
    function automatic logic [3:0] load_cnt(input logic [3:0] n);
        return (n == 4'd0) ? 4'd0 : n - 4'd1;
    endfunction
endpackage

// File: rtl/sdr_cmd_bank_track.sv
// sdr_cmd_bank_track: one bank's open/idle flag, its tRP/tRCD windows and bank-level violations
module sdr_cmd_bank_track
    import sdr_cmd_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cmd_en,
    input  logic       sel,
    input  logic [2:0] cmd,
    input  logic       sa10,
    input  logic [2:0] rp,
    input  logic [2:0] rcd,
    output logic       err_trp,
    output logic       err_trcd,
    output logic       err_bank
);
    logic       active, is_act, is_rw, is_pre, is_ref, closes;
    logic [2:0] trp, trcd;
    always_comb begin
        is_act   = cmd_en && sel && cmd == CMD_ACT;
        is_rw    = cmd_en && sel && (cmd == CMD_READ || cmd == CMD_WRITE);
        is_pre   = cmd_en && cmd == CMD_PRE && (sel || sa10);
        is_ref   = cmd_en && cmd == CMD_REF;
        closes   = is_pre || (is_rw && sa10);
        err_trp  = is_act && trp != 3'd0;
        err_trcd = is_rw && trcd != 3'd0;
        err_bank = (is_act && active) || (is_rw && !active) || (is_ref && active);
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            active <= 1'b0;
            trp    <= 3'd0;
            trcd   <= 3'd0;
        end else begin
            active <= is_act ? 1'b1 : closes ? 1'b0 : active;
            trp    <= closes ? 3'(load_cnt({1'b0, rp})) : trp - 3'(trp != 3'd0);
            trcd   <= is_act ? 3'(load_cnt({1'b0, rcd})) : trcd - 3'(trcd != 3'd0);
        end
    end
endmodule

// File: rtl/sdr_cmd_monitor.sv
// sdr_cmd_monitor: passive SDR SDRAM command-bus monitor tracking init, mode, bank state and timing windows
module sdr_cmd_monitor
    import sdr_cmd_pkg::*;
#(
    parameter int SDRAM_CHIPS = 8,
    parameter int INIT_REFS   = 8,
    parameter int REF_SLACK   = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [SDRAM_CHIPS-1:0] CS_N,
    input  logic                   RAS_N,
    input  logic                   CAS_N,
    input  logic                   WE_N,
    input  logic                   CKE,
    input  logic [1:0]             BA,
    input  logic [13:0]            SA,
    input  logic [2:0]             RP,
    input  logic [2:0]             RCD,
    input  logic [3:0]             RFC,
    input  logic [2:0]             MRD,
    input  logic [15:0]            REF,
    input  logic                   ERR_CLR,
    output logic                   CMD_VALID,
    output logic [2:0]             CMD,
    output logic [1:0]             CMD_BANK,
    output logic                   INIT_DONE,
    output logic [2:0]             MODE_CL,
    output logic [2:0]             MODE_BL,
    output logic [15:0]            REF_CNT,
    output logic [6:0]             ERR,
    output logic [6:0]             ERR_STICKY
);
    localparam int RW = $clog2(INIT_REFS + 1);
    init_e         state, state_nx;
    logic [RW-1:0] init_refs;
    logic [2:0]    cmd, tmrd;
    logic [3:0]    trfc, b_trp, b_trcd, b_bank;
    logic [16:0]   ref_tmr;
    logic [6:0]    err_nx;
    logic          cmd_on, is_ref, is_mrs, is_pre_all, is_data, bank_en, done;
    logic          err_init, err_late, ref_fired, mode_cap, sa_unused;
    always_comb begin
        cmd        = {RAS_N, CAS_N, WE_N};
        cmd_on     = CKE && !(&CS_N) && cmd != CMD_NOP;
        is_ref     = cmd_on && cmd == CMD_REF;
        is_mrs     = cmd_on && cmd == CMD_MRS;
        is_pre_all = cmd_on && cmd == CMD_PRE && SA[10];
        is_data    = cmd == CMD_ACT || cmd == CMD_READ || cmd == CMD_WRITE || cmd == CMD_BST;
        bank_en    = cmd_on && (done || !is_data);
        mode_cap   = is_mrs && (state == WAIT_MRS || done);
        sa_unused  = ^{SA[13:11], SA[9:7], SA[3]};
    end
    always_ff @(posedge CLK) state <= RESET ? WAIT_PRE : state_nx;
    always_comb begin
        state_nx = (state == WAIT_PRE && is_pre_all) ? WAIT_REF :
                   (state == WAIT_REF && is_ref && init_refs == RW'(INIT_REFS - 1)) ? WAIT_MRS :
                   (state == WAIT_MRS && is_mrs) ? DONE : state;
    end
    always_comb begin
        done      = state == DONE;
        INIT_DONE = done;
        err_init  = cmd_on && ((state == WAIT_PRE && !is_pre_all) || (!done && is_data));
    end
    // data commands rejected during init never reach the bank model
    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdr_cmd_bank_track u_bank (
            .CLK      (CLK),
            .RESET    (RESET),
            .cmd_en   (bank_en),
            .sel      (BA == 2'(b)),
            .cmd      (cmd),
            .sa10     (SA[10]),
            .rp       (RP),
            .rcd      (RCD),
            .err_trp  (b_trp[b]),
            .err_trcd (b_trcd[b]),
            .err_bank (b_bank[b])
        );
    end
    always_comb begin
        err_late               = done && !ref_fired && ref_tmr >= {1'b0, REF} + 17'(REF_SLACK);
        err_nx                 = '0;
        err_nx[ERR_INIT]       = err_init;
        err_nx[ERR_TRP]        = |b_trp;
        err_nx[ERR_TRCD]       = |b_trcd;
        err_nx[ERR_TRFC]       = cmd_on && trfc != 4'd0;
        err_nx[ERR_TMRD]       = cmd_on && tmrd != 3'd0;
        err_nx[ERR_BANK]       = |b_bank;
        err_nx[ERR_REF_LATE]   = err_late;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            init_refs  <= '0;
            trfc       <= 4'd0;
            tmrd       <= 3'd0;
            ref_tmr    <= '0;
            ref_fired  <= 1'b0;
            CMD_VALID  <= 1'b0;
            CMD        <= 3'd0;
            CMD_BANK   <= 2'd0;
            MODE_CL    <= 3'd0;
            MODE_BL    <= 3'd0;
            REF_CNT    <= 16'd0;
            ERR        <= 7'd0;
            ERR_STICKY <= 7'd0;
        end else begin
            init_refs  <= init_refs + RW'(state == WAIT_REF && is_ref);
            trfc       <= is_ref ? load_cnt(RFC) : trfc - 4'(trfc != 4'd0);
            tmrd       <= is_mrs ? 3'(load_cnt({1'b0, MRD})) : tmrd - 3'(tmrd != 3'd0);
            ref_tmr    <= (!done || is_ref) ? '0 : ref_tmr + 17'(!(&ref_tmr));
            ref_fired  <= !is_ref && (ref_fired || err_late);
            CMD_VALID  <= cmd_on;
            CMD        <= cmd_on ? cmd : CMD;
            CMD_BANK   <= cmd_on ? BA : CMD_BANK;
            MODE_CL    <= mode_cap ? SA[6:4] : MODE_CL;
            MODE_BL    <= mode_cap ? SA[2:0] : MODE_BL;
            REF_CNT    <= REF_CNT + 16'(done && is_ref);
            ERR        <= err_nx;
            ERR_STICKY <= ERR_CLR ? 7'd0 : ERR_STICKY | ERR;
        end
    end
endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// tb_sdr_cmd_monitor: vector tables plus hand sequences for init, timing windows, bank state and refresh interval
module tb_sdr_cmd_monitor;
    localparam logic [2:0] MRS = 3'b000, REFC = 3'b001, PRE = 3'b010, ACT = 3'b011;
    localparam logic [2:0] WR = 3'b100, RD = 3'b101, NOP = 3'b111;
    localparam logic [6:0] E_INIT = 7'h01, E_TRP = 7'h02, E_TRCD = 7'h04, E_TRFC = 7'h08;
    localparam logic [6:0] E_TMRD = 7'h10, E_BANK = 7'h20, E_LATE = 7'h40;

    typedef struct {
        logic [2:0]  cmd;
        logic [1:0]  ba;
        logic [13:0] sa;
        logic        cke;
        logic [7:0]  cs;
        logic [6:0]  err;
    } vec_t;
    typedef struct {
        logic       v;
        logic [2:0] cmd;
        logic [1:0] ba;
        logic [6:0] err;
    } exp_t;

    logic        CLK = 1'b0, RESET = 1'b1, RAS_N = 1'b1, CAS_N = 1'b1, WE_N = 1'b1, CKE = 1'b1, ERR_CLR = 1'b0;
    logic [7:0]  CS_N = 8'hFF;
    logic [1:0]  BA = 2'd0;
    logic [13:0] SA = 14'd0;
    logic [2:0]  RP = 3'd2, RCD = 3'd3, MRD = 3'd2;
    logic [3:0]  RFC = 4'd7;
    logic [15:0] REF = 16'd100;
    logic        CMD_VALID, INIT_DONE;
    logic [2:0]  CMD, MODE_CL, MODE_BL;
    logic [1:0]  CMD_BANK;
    logic [15:0] REF_CNT;
    logic [6:0]  ERR, ERR_STICKY;

    int   total = 0, bad = 0;
    vec_t tbl[$];
    exp_t sb[$];

    sdr_cmd_monitor #(.SDRAM_CHIPS(8), .INIT_REFS(8), .REF_SLACK(16)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N),
        .CKE(CKE), .BA(BA), .SA(SA), .RP(RP), .RCD(RCD), .RFC(RFC), .MRD(MRD), .REF(REF),
        .ERR_CLR(ERR_CLR), .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_BANK(CMD_BANK),
        .INIT_DONE(INIT_DONE), .MODE_CL(MODE_CL), .MODE_BL(MODE_BL), .REF_CNT(REF_CNT),
        .ERR(ERR), .ERR_STICKY(ERR_STICKY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end (bad=%0d)", bad);
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [2:0] c, input logic [1:0] ba, input logic [13:0] sa, input logic [6:0] e);
        vec_t r;
        r.cmd = c; r.ba = ba; r.sa = sa; r.cke = 1'b1; r.cs = 8'hFB; r.err = e;
        return r;
    endfunction

    function automatic vec_t vx(input logic [2:0] c, input logic cke, input logic [7:0] cs);
        vec_t r;
        r = v(c, 2'd3, 14'd0, 7'd0);
        r.cke = cke; r.cs = cs;
        return r;
    endfunction

    task automatic apply(input vec_t x, input string nm);
        exp_t e;
        {RAS_N, CAS_N, WE_N} = x.cmd;
        BA = x.ba; SA = x.sa; CKE = x.cke; CS_N = x.cs;
        sb.push_back('{x.cke && x.cs != 8'hFF && x.cmd != NOP, x.cmd, x.ba, x.err});
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk({nm, " err"}, 64'(ERR), 64'(e.err));
        chk({nm, " valid"}, 64'(CMD_VALID), 64'(e.v));
        if (e.v) chk({nm, " cmd/bank"}, 64'({CMD, CMD_BANK}), 64'({e.cmd, e.ba}));
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("%s[%0d]", nm, i));
        tbl.delete();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) tbl.push_back(v(NOP, 2'd0, 14'd0, 7'd0));
    endtask

    task automatic do_reset(input string nm);
        RESET = 1'b1;
        {RAS_N, CAS_N, WE_N} = NOP; CS_N = 8'hFF;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        chk(nm, {21'd0, CMD_VALID, CMD, CMD_BANK, INIT_DONE, MODE_CL, MODE_BL, REF_CNT, ERR, ERR_STICKY}, 64'd0);
    endtask

    initial begin
        @(posedge CLK);
        do_reset("reset_start");

        // init: bad precharge, good precharge, 8 refreshes, premature ACT
        tbl.push_back(v(PRE, 2'd0, 14'h000, E_INIT));
        tbl.push_back(v(PRE, 2'd0, 14'h400, 7'd0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(v(REFC, 2'd0, 14'd0, 7'd0));
            nops(7);
        end
        tbl.push_back(v(ACT, 2'd1, 14'd0, E_INIT));
        nops(1);
        run_table("init");
        chk("sticky_after_init_err", 64'(ERR_STICKY), 64'(E_INIT));
        chk("done_before_mrs", 64'(INIT_DONE), 64'd0);
        ERR_CLR = 1'b1;
        apply(v(NOP, 2'd0, 14'd0, 7'd0), "clr");
        ERR_CLR = 1'b0;
        chk("sticky_cleared", 64'(ERR_STICKY), 64'd0);
        apply(v(MRS, 2'd0, 14'h030, 7'd0), "mrs_init");
        chk("init_done", 64'(INIT_DONE), 64'd1);
        chk("mode_cl", 64'(MODE_CL), 64'd3);
        chk("mode_bl", 64'(MODE_BL), 64'd0);
        chk("sticky_clean", 64'(ERR_STICKY), 64'd0);

        // post-init timing and bank state
        tbl.push_back(vx(ACT, 1'b0, 8'hFB));
        tbl.push_back(vx(ACT, 1'b1, 8'hFF));
        tbl.push_back(v(ACT, 2'd2, 14'd0, 7'd0));
        nops(1);
        tbl.push_back(v(RD, 2'd2, 14'd0, E_TRCD));
        tbl.push_back(v(RD, 2'd2, 14'd0, 7'd0));
        tbl.push_back(v(PRE, 2'd2, 14'd0, 7'd0));
        tbl.push_back(v(ACT, 2'd2, 14'd0, E_TRP));
        tbl.push_back(v(ACT, 2'd0, 14'd0, 7'd0));
        tbl.push_back(v(ACT, 2'd0, 14'd0, E_BANK));
        nops(2);
        tbl.push_back(v(WR, 2'd0, 14'h400, 7'd0));
        nops(1);
        tbl.push_back(v(ACT, 2'd0, 14'd0, 7'd0));
        nops(2);
        tbl.push_back(v(WR, 2'd0, 14'h400, 7'd0));
        tbl.push_back(v(ACT, 2'd0, 14'd0, E_TRP));
        tbl.push_back(v(RD, 2'd3, 14'd0, E_BANK));
        tbl.push_back(v(REFC, 2'd0, 14'd0, E_BANK));
        nops(5);
        tbl.push_back(v(PRE, 2'd0, 14'h400, E_TRFC));
        nops(1);
        tbl.push_back(v(MRS, 2'd0, 14'h022, 7'd0));
        tbl.push_back(v(ACT, 2'd1, 14'd0, E_TMRD));
        nops(1);
        tbl.push_back(v(MRS, 2'd0, 14'h022, 7'd0));
        tbl.push_back(v(ACT, 2'd1, 14'd0, E_TMRD | E_BANK));
        tbl.push_back(v(PRE, 2'd0, 14'h400, 7'd0));
        run_table("run");
        chk("mode_cl_recap", 64'(MODE_CL), 64'd2);
        chk("mode_bl_recap", 64'(MODE_BL), 64'd2);
        chk("ref_cnt_1", 64'(REF_CNT), 64'd1);

        // refresh interval: late pulse 117 commands after REF, once, re-armed by REF
        for (int r = 0; r < 2; r++) begin
            apply(v(REFC, 2'd0, 14'd0, 7'd0), "late_ref");
            chk("ref_cnt_late", 64'(REF_CNT), 64'(r + 2));
            for (int n = 1; n <= 122; n++)
                apply(v(NOP, 2'd0, 14'd0, (n == 117) ? E_LATE : 7'd0), $sformatf("late%0d_%0d", r, n));
        end

        // ERR_CLR against a simultaneous error
        ERR_CLR = 1'b1;
        apply(v(RD, 2'd1, 14'd0, E_BANK), "clr_rd");
        chk("sticky_clr_wins", 64'(ERR_STICKY), 64'd0);
        ERR_CLR = 1'b0;
        apply(v(NOP, 2'd0, 14'd0, 7'd0), "clr_nop");
        chk("sticky_reaccum", 64'(ERR_STICKY), 64'(E_BANK));
        ERR_CLR = 1'b1;
        apply(v(NOP, 2'd0, 14'd0, 7'd0), "clr_nop2");
        ERR_CLR = 1'b0;
        chk("sticky_clr2", 64'(ERR_STICKY), 64'd0);

        // reset mid-WAIT_REF discards the sequence
        do_reset("reset_done");
        tbl.push_back(v(PRE, 2'd0, 14'h400, 7'd0));
        for (int i = 0; i < 3; i++) begin
            tbl.push_back(v(REFC, 2'd0, 14'd0, 7'd0));
            nops(7);
        end
        run_table("reinit");
        do_reset("reset_mid");
        apply(v(MRS, 2'd0, 14'h030, E_INIT), "mrs_after_reset");
        chk("done_after_reset", 64'(INIT_DONE), 64'd0);
        chk("mode_after_reset", 64'({MODE_CL, MODE_BL}), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sdr_cmd_monitor.md
Name: sdr_cmd_monitor

Overview:
- Passive responder-side monitor for the SDR SDRAM command bus driven by the controller's init/refresh engine and command sequencer.
- Decodes CS_N/RAS_N/CAS_N/WE_N/BA/SA every cycle.
- Tracks the init sequence, mode register, per-bank open/idle state and timing windows (tRP, tRCD, tRFC, tMRD, refresh interval).
- Flags protocol violations; sits alongside the memory pins in the FPGA for on-chip debug and for bench scoreboarding.

Parameters:
SDRAM_CHIPS, 8, width of CS_N.
INIT_REFS, 8, auto-refreshes required between init precharge and MRS.
REF_SLACK, 16, extra clocks beyond REF tolerated before refresh-late error.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CS_N  in  SDRAM_CHIPS  chip selects; command valid when any bit low
RAS_N  in  1  command bit
CAS_N  in  1  command bit
WE_N  in  1  command bit
CKE  in  1  clock enable; low -> command treated as NOP
BA  in  2  bank address
SA  in  14  address; SA[10] = all-banks / auto-precharge flag
RP  in  3  tRP clocks
RCD  in  3  tRCD clocks
RFC  in  4  tRFC clocks
MRD  in  3  tMRD clocks
REF  in  16  refresh period in clocks
ERR_CLR  in  1  clears ERR_STICKY
CMD_VALID  out  1  one-cycle strobe: decoded non-NOP command
CMD  out  3  decoded {RAS_N,CAS_N,WE_N}
CMD_BANK  out  2  BA of decoded command
INIT_DONE  out  1  valid init sequence completed
MODE_CL  out  3  SA[6:4] captured at MRS
MODE_BL  out  3  SA[2:0] captured at MRS
REF_CNT  out  16  auto-refreshes since INIT_DONE, wraps at 0xFFFF->0
ERR  out  7  one-cycle violation pulse vector
ERR_STICKY  out  7  accumulated ERR

Behaviour:
- Reset (RESET high at posedge): every output 0; all banks idle; timing counters 0; init FSM = WAIT_PRE. Also applies mid-sequence: all state discarded.
- Encodings {RAS_N,CAS_N,WE_N}: ACT 011, READ 101, WRITE 100, BST 110, PRE 010, REF 001, MRS 000, NOP 111.
- No command when all CS_N high or CKE low. Chip index is ignored (single-rank state model).
- All outputs registered: a command sampled at edge t produces outputs valid after edge t+1.
- Init FSM:
  - WAIT_PRE: next command must be PRE with SA[10]=1 -> WAIT_REF; any other command sets ERR[0].
  - WAIT_REF: counts REFs; the INIT_REFS-th REF -> WAIT_MRS.
  - WAIT_MRS: MRS -> DONE, capture MODE_CL/MODE_BL, INIT_DONE=1.
  - Before DONE, ACT/READ/WRITE/BST set ERR[0] and the FSM does not advance.
  - In DONE, further MRS re-captures the mode fields.
- Timing counters (per bank: trp, trcd; global: trfc, tmrd):
  - Issuing command loads N-1, saturating at 0 for N=0. Counter decrements to 0 each subsequent cycle.
  - A dependent command is legal when the counter is 0, i.e. N cycles after the issuing command.
  - PRE -> ACT to the same bank: ERR[1].
  - ACT -> READ/WRITE to the same bank: ERR[2].
  - REF -> any command except NOP: ERR[3].
  - MRS -> any command except NOP: ERR[4].
  - PRE all-banks loads all bank trp counters.
- Bank state:
  - ACT to an active bank: ERR[5].
  - READ/WRITE to an idle bank: ERR[5].
  - REF while any bank active: ERR[5].
  - PRE to an idle bank is legal.
  - READ/WRITE with SA[10]=1 returns the bank to idle and loads trp.
- Refresh interval: after INIT_DONE, a 17-bit counter clears on each REF and increments otherwise, saturating. When it reaches REF+REF_SLACK, ERR[6] pulses once. It re-arms only after the next REF.
- Same-cycle events: several error bits may pulse together. ERR_STICKY <= (ERR_STICKY | ERR), but ERR_CLR wins for that cycle (the new ERR is still accumulated next cycle if it repeats).
- REF_CNT increments only in DONE.

Decomposition:
- Package sdr_cmd_pkg:
  - command encodings
  - ERR bit indices (INIT=0, TRP=1, TRCD=2, TRFC=3, TMRD=4, BANK=5, REF_LATE=6)
  - init FSM state encoding
- Sub-module sdr_cmd_bank_track, instantiated 4 times: per-bank active flag, trp and trcd counters, per-bank ERR[1]/ERR[2]/ERR[5] contributions.

Test Plan:
- Clean init with RP=2, RFC=7, MRD=2: PRE(SA10=1), 8 REF spaced 8 clocks, MRS SA=0x030 -> INIT_DONE=1, MODE_CL=3, MODE_BL=0, ERR_STICKY=0.
- ACT bank1 before MRS -> ERR[0] pulse one cycle after the command; FSM stays in WAIT_MRS; a later MRS still completes init.
- After init, RCD=3: ACT bank2 at t, READ bank2 at t+2 -> ERR[2]. Repeat with READ at t+3 -> no error.
- ACT bank0 twice without PRE -> ERR[5]. WRITE SA10=1 then ACT at +RP clocks -> clean. ACT at +RP-1 clocks -> ERR[1].
- REF=100, REF_SLACK=16: no REF for 116 clocks -> single ERR[6] pulse. Next REF -> REF_CNT+1; the error re-arms.
- RESET asserted mid-WAIT_REF and ERR_CLR with a simultaneous error -> all outputs 0 after reset; ERR_STICKY=0 on the clear cycle.
